// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module DMI target: register addresses,
// DMI op/response encodings, abstract-command error codes and field positions.
package dm_pkg;

  // DMI register addresses
  localparam int unsigned DATA0      = 'h04;
  localparam int unsigned DMCONTROL  = 'h10;
  localparam int unsigned DMSTATUS   = 'h11;
  localparam int unsigned HARTINFO   = 'h12;
  localparam int unsigned ABSTRACTCS = 'h16;
  localparam int unsigned COMMAND    = 'h17;

  typedef enum logic [1:0] {
    DmiNop   = 2'd0,
    DmiRead  = 2'd1,
    DmiWrite = 2'd2,
    DmiRsvd  = 2'd3
  } dmi_op_t;

  typedef enum logic [1:0] {
    DmiSuccess = 2'd0,
    DmiFailed  = 2'd2
  } dmi_rsp_t;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BUSY      = 3'd1,
    NOTSUP    = 3'd2,
    EXCEPTION = 3'd3
  } cmderr_t;

  // dmcontrol fields
  localparam int unsigned HaltreqBit   = 31;
  localparam int unsigned ResumereqBit = 30;
  localparam int unsigned NdmresetBit  = 1;
  localparam int unsigned DmactiveBit  = 0;

  // abstractcs fields
  localparam int unsigned AcsCmderrLsb = 8;
  localparam int unsigned AcsBusyBit   = 12;

  // command fields
  localparam int unsigned CmdTypeLsb  = 24;
  localparam int unsigned AarsizeLsb  = 20;
  localparam int unsigned TransferBit = 17;
  localparam int unsigned WriteBit    = 16;
  localparam logic [2:0]  Aarsize32   = 3'd2;

endpackage

// File: rtl/dm_abstract_fsm.sv
// Abstract-command engine: owns data0, cmderr and the IDLE/ACCESS state that
// drives the hart register port.
// Ports:
//   clk, rst           clock, async active-high reset
//   active             next-cycle dmactive; low clears data0/cmderr and aborts
//   data0_we/_wdata    data0 write strobe and value
//   data0_re           data0 read strobe (busy violation source)
//   cmd_we/_wdata      command write strobe and value
//   acs_we/_w1c        abstractcs write strobe and cmderr W1C mask
//   ar_done/err/rdata  hart register port completion
//   view_*             busy/cmderr/data0 as seen by a request this cycle
//   busy, ar_*         state and hart register port request
module dm_abstract_fsm
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        data0_we,
  input  logic [31:0] data0_wdata,
  input  logic        data0_re,
  input  logic        cmd_we,
  input  logic [31:0] cmd_wdata,
  input  logic        acs_we,
  input  logic [2:0]  acs_w1c,
  input  logic        ar_done,
  input  logic        ar_err,
  input  logic [31:0] ar_rdata,
  output logic        view_busy,
  output logic [2:0]  view_cmderr,
  output logic [31:0] view_data0,
  output logic        busy,
  output logic        ar_valid,
  output logic        ar_write,
  output logic [15:0] ar_regno,
  output logic [31:0] ar_wdata
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [31:0] data0_q, data0_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        ar_write_q, ar_write_d;
  logic [15:0] ar_regno_q, ar_regno_d;
  logic [31:0] ar_wdata_q, ar_wdata_d;
  logic        access, done_now, violation, cmd_bad;
  logic        unused_cmd;

  assign unused_cmd = cmd_wdata[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_q    <= '0;
      cmderr_q   <= NONE;
      ar_write_q <= 1'b0;
      ar_regno_q <= '0;
      ar_wdata_q <= '0;
    end else begin
      data0_q    <= data0_d;
      cmderr_q   <= cmderr_d;
      ar_write_q <= ar_write_d;
      ar_regno_q <= ar_regno_d;
      ar_wdata_q <= ar_wdata_d;
    end
  end

  // Completion is folded in before the request is examined, so a request
  // arriving with ar_done already sees IDLE and the updated data0/cmderr.
  always_comb begin
    access      = (state_q == StAccess);
    done_now    = access & ar_done;
    busy        = access;
    ar_valid    = access;
    ar_write    = ar_write_q;
    ar_regno    = ar_regno_q;
    ar_wdata    = ar_wdata_q;
    view_busy   = access & ~ar_done;
    view_data0  = (done_now && !ar_err && !ar_write_q) ? ar_rdata : data0_q;
    view_cmderr = (done_now && ar_err) ? EXCEPTION : cmderr_q;
  end

  always_comb begin
    state_d    = view_busy ? StAccess : StIdle;
    data0_d    = view_data0;
    cmderr_d   = view_cmderr;
    ar_write_d = ar_write_q;
    ar_regno_d = ar_regno_q;
    ar_wdata_d = ar_wdata_q;
    violation  = cmd_we | acs_we | data0_we | data0_re;
    cmd_bad    = (cmd_wdata[CmdTypeLsb +: 8] != 8'd0) ||
                 (cmd_wdata[AarsizeLsb +: 3] != Aarsize32);
    if (view_busy) begin
      if (violation && view_cmderr == NONE) cmderr_d = BUSY;
    end else begin
      if (data0_we) data0_d = data0_wdata;
      if (acs_we)   cmderr_d = view_cmderr & ~acs_w1c;
      if (cmd_we && view_cmderr == NONE) begin
        if (cmd_bad) begin
          cmderr_d = NOTSUP;
        end else if (cmd_wdata[TransferBit]) begin
          state_d    = StAccess;
          ar_write_d = cmd_wdata[WriteBit];
          ar_regno_d = cmd_wdata[15:0];
          ar_wdata_d = view_data0;
        end
      end
    end
    if (!active) begin
      state_d  = StIdle;
      data0_d  = '0;
      cmderr_d = NONE;
    end
  end

endmodule

// File: rtl/dm_dmi_target.sv
// Debug Module DMI register target: accepts one DMI request at a time, answers
// one cycle later, and drives halt/resume/ndmreset plus abstract register access.
// Ports:
//   tclk, trst                       clock, async active-high reset
//   req_valid/ready/addr/data/op     DMI request channel
//   rsp_valid/ready/data/op          DMI response channel
//   haltreq, resumereq, ndmreset     hart run control
//   hart_halted, hart_resumeack      hart status
//   ar_valid/write/regno/wdata       abstract register access request
//   ar_done/err/rdata                abstract register access completion
module dm_dmi_target
  import dm_pkg::*;
#(
  parameter int unsigned ABITS        = 7,
  parameter logic [31:0] HARTINFO_VAL = 32'h0
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_op,
  output logic             haltreq,
  output logic             resumereq,
  output logic             ndmreset,
  input  logic             hart_halted,
  input  logic             hart_resumeack,
  output logic             ar_valid,
  output logic             ar_write,
  output logic [15:0]      ar_regno,
  output logic [31:0]      ar_wdata,
  input  logic             ar_done,
  input  logic             ar_err,
  input  logic [31:0]      ar_rdata
);

  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_op_q;
  logic        dmactive_q, dmactive_d, haltreq_q, haltreq_d;
  logic        ndmreset_q, ndmreset_d, resumereq_q, resumereq_d;
  logic        sticky_q, sticky_d;
  logic        accept, is_read, is_write;
  logic        sel_data0, sel_ctrl, sel_status, sel_info, sel_acs, sel_cmd;
  logic        view_busy;
  logic [2:0]  view_cmderr;
  logic [31:0] view_data0, rdata;

  assign req_ready = ~rsp_valid_q;
  assign accept    = req_valid & req_ready;
  assign is_read   = accept & (req_op == DmiRead);
  assign is_write  = accept & (req_op == DmiWrite);

  assign sel_data0  = (req_addr == ABITS'(DATA0));
  assign sel_ctrl   = (req_addr == ABITS'(DMCONTROL));
  assign sel_status = (req_addr == ABITS'(DMSTATUS));
  assign sel_info   = (req_addr == ABITS'(HARTINFO));
  assign sel_acs    = (req_addr == ABITS'(ABSTRACTCS));
  assign sel_cmd    = (req_addr == ABITS'(COMMAND));

  dm_abstract_fsm u_abstract (
    .clk         (tclk),
    .rst         (trst),
    .active      (dmactive_d),
    .data0_we    (is_write & sel_data0 & dmactive_q),
    .data0_wdata (req_data),
    .data0_re    (is_read & sel_data0 & dmactive_q),
    .cmd_we      (is_write & sel_cmd & dmactive_q),
    .cmd_wdata   (req_data),
    .acs_we      (is_write & sel_acs & dmactive_q),
    .acs_w1c     (req_data[AcsCmderrLsb +: 3]),
    .ar_done     (ar_done),
    .ar_err      (ar_err),
    .ar_rdata    (ar_rdata),
    .view_busy   (view_busy),
    .view_cmderr (view_cmderr),
    .view_data0  (view_data0),
    .busy        (),
    .ar_valid    (ar_valid),
    .ar_write    (ar_write),
    .ar_regno    (ar_regno),
    .ar_wdata    (ar_wdata)
  );

  always_comb begin
    rdata = '0;
    if (sel_data0) begin
      rdata = view_busy ? 32'd0 : view_data0;
    end else if (sel_ctrl) begin
      rdata[HaltreqBit]  = haltreq_q;
      rdata[NdmresetBit] = ndmreset_q;
      rdata[DmactiveBit] = dmactive_q;
    end else if (sel_status) begin
      rdata[3:0]   = 4'd2;
      rdata[7]     = 1'b1;
      rdata[9:8]   = {2{hart_halted}};
      rdata[11:10] = {2{~hart_halted}};
      rdata[17:16] = {2{sticky_q}};
    end else if (sel_info) begin
      rdata = HARTINFO_VAL;
    end else if (sel_acs) begin
      rdata[3:0]                = 4'd1;
      rdata[AcsCmderrLsb +: 3]  = view_cmderr;
      rdata[AcsBusyBit]         = view_busy;
    end
  end

  always_comb begin
    dmactive_d  = dmactive_q;
    haltreq_d   = haltreq_q;
    ndmreset_d  = ndmreset_q;
    resumereq_d = resumereq_q;
    sticky_d    = sticky_q;
    if (resumereq_q && hart_resumeack) begin
      resumereq_d = 1'b0;
      sticky_d    = 1'b1;
    end
    if (is_write && sel_ctrl) begin
      dmactive_d = req_data[DmactiveBit];
      if (req_data[DmactiveBit]) begin
        haltreq_d  = req_data[HaltreqBit];
        ndmreset_d = req_data[NdmresetBit];
        // A combined halt+resume write only halts.
        if (req_data[ResumereqBit] && !req_data[HaltreqBit]) begin
          resumereq_d = 1'b1;
          sticky_d    = 1'b0;
        end
      end
    end
    if (!dmactive_d) begin
      haltreq_d  = 1'b0;
      ndmreset_d = 1'b0;
    end
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      resumereq_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      dmactive_q  <= dmactive_d;
      haltreq_q   <= haltreq_d;
      ndmreset_q  <= ndmreset_d;
      resumereq_q <= resumereq_d;
      sticky_q    <= sticky_d;
    end
  end

  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= DmiSuccess;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= is_read ? rdata : 32'd0;
      rsp_op_q    <= (req_op == DmiRsvd) ? DmiFailed : DmiSuccess;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign haltreq   = haltreq_q;
  assign resumereq = resumereq_q;
  assign ndmreset  = ndmreset_q;

endmodule

// File: tb/tb_dm_dmi_target.sv
module tb_dm_dmi_target;

  localparam logic [31:0] HartInfo = 32'hCAFE_0123;

  logic        tclk = 1'b0;
  logic        trst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data, rsp_data;
  logic [1:0]  req_op, rsp_op;
  logic        haltreq, resumereq, ndmreset, hart_halted, hart_resumeack;
  logic        ar_valid, ar_write, ar_done, ar_err;
  logic [15:0] ar_regno;
  logic [31:0] ar_wdata, ar_rdata;

  always #5 tclk = ~tclk;

  dm_dmi_target #(.ABITS(7), .HARTINFO_VAL(HartInfo)) dut (
    .tclk(tclk), .trst(trst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
    .haltreq(haltreq), .resumereq(resumereq), .ndmreset(ndmreset),
    .hart_halted(hart_halted), .hart_resumeack(hart_resumeack),
    .ar_valid(ar_valid), .ar_write(ar_write), .ar_regno(ar_regno), .ar_wdata(ar_wdata),
    .ar_done(ar_done), .ar_err(ar_err), .ar_rdata(ar_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register-level view of the debug module.
  logic        m_active, m_haltreq, m_ndmreset, m_resumereq, m_sticky, m_busy, m_ar_write;
  logic [31:0] m_data0, m_wdata;
  logic [2:0]  m_cmderr;
  logic [15:0] m_regno;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_haltreq = 0; m_ndmreset = 0; m_resumereq = 0; m_sticky = 0;
    m_busy = 0; m_ar_write = 0; m_data0 = 0; m_wdata = 0; m_cmderr = 0; m_regno = 0;
  endfunction

  function automatic void model_done(input logic err, input logic [31:0] rdata);
    if (m_busy) begin
      m_busy = 0;
      if (err) m_cmderr = 3'd3;
      else if (!m_ar_write) m_data0 = rdata;
    end
  endfunction

  function automatic void model_dmi(input logic [1:0] op, input logic [6:0] a,
                                    input logic [31:0] wd,
                                    output logic [31:0] rd, output logic [1:0] ro);
    rd = '0;
    ro = (op == 2'd3) ? 2'd2 : 2'd0;
    if (op == 2'd1) begin
      case (a)
        7'h04: begin
          if (m_busy) begin
            if (m_cmderr == 0) m_cmderr = 3'd1;
          end else rd = m_data0;
        end
        7'h10: rd = {m_haltreq, 29'd0, m_ndmreset, m_active};
        7'h11: rd = 32'h82 | (hart_halted ? 32'h300 : 32'hC00) |
                    (m_sticky ? 32'h3_0000 : 32'h0);
        7'h12: rd = HartInfo;
        7'h16: rd = 32'h1 | (m_busy ? 32'h1000 : 32'h0) | (32'(m_cmderr) << 8);
        default: rd = '0;
      endcase
    end else if (op == 2'd2) begin
      if (a == 7'h10) begin
        m_active = wd[0];
        if (wd[0]) begin
          m_haltreq  = wd[31];
          m_ndmreset = wd[1];
          if (wd[30] && !wd[31]) begin
            m_resumereq = 1;
            m_sticky    = 0;
          end
        end else begin
          m_haltreq = 0; m_ndmreset = 0; m_data0 = 0; m_cmderr = 0; m_busy = 0;
        end
      end else if (m_active) begin
        if (m_busy && (a == 7'h04 || a == 7'h16 || a == 7'h17)) begin
          if (m_cmderr == 0) m_cmderr = 3'd1;
        end else if (a == 7'h04) begin
          m_data0 = wd;
        end else if (a == 7'h16) begin
          m_cmderr = m_cmderr & ~wd[10:8];
        end else if (a == 7'h17 && m_cmderr == 0) begin
          if (wd[31:24] != 0 || wd[22:20] != 3'd2) m_cmderr = 3'd2;
          else if (wd[17]) begin
            m_busy = 1; m_ar_write = wd[16]; m_regno = wd[15:0]; m_wdata = m_data0;
          end
        end
      end
    end
  endfunction

  // One complete DMI transaction, optionally with ar_done in the accept cycle.
  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                     input int unsigned hold, input logic done_en, input logic done_err,
                     input logic [31:0] done_rdata,
                     output logic [31:0] rd, output logic [1:0] ro);
    logic [31:0] erd;
    logic [1:0]  ero;
    @(negedge tclk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_op = op; req_addr = a; req_data = wd;
    if (done_en) begin
      ar_done = 1; ar_err = done_err; ar_rdata = done_rdata;
      model_done(done_err, done_rdata);
    end
    model_dmi(op, a, wd, erd, ero);
    @(posedge tclk); #1;
    req_valid = 0; req_op = 0; ar_done = 0; ar_err = 0;
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    check("req_ready_held", 32'(req_ready), 32'd0);
    check($sformatf("rsp_data@%02h", a), rsp_data, erd);
    check($sformatf("rsp_op@%02h", a), 32'(rsp_op), 32'(ero));
    rd = rsp_data;
    ro = rsp_op;
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge tclk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, erd);
      check("hold_op", 32'(rsp_op), 32'(ero));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge tclk); rsp_ready = 1;
    @(posedge tclk); #1; rsp_ready = 0;
    check("rsp_cleared", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic [1:0]  o;
    dmi(2'd2, a, d, 0, 1'b0, 1'b0, 32'd0, x, o);
  endtask

  task automatic rdr(input logic [6:0] a, output logic [31:0] d);
    logic [1:0] o;
    dmi(2'd1, a, 32'd0, 0, 1'b0, 1'b0, 32'd0, d, o);
  endtask

  task automatic pulse_done(input logic err, input logic [31:0] rdata);
    @(negedge tclk); ar_done = 1; ar_err = err; ar_rdata = rdata;
    model_done(err, rdata);
    @(posedge tclk); #1; ar_done = 0; ar_err = 0;
  endtask

  task automatic pulse_ack();
    @(negedge tclk); hart_resumeack = 1;
    if (m_resumereq) begin m_resumereq = 0; m_sticky = 1; end
    @(posedge tclk); #1; hart_resumeack = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".haltreq"}, 32'(haltreq), 32'(m_haltreq));
    check({tag, ".resumereq"}, 32'(resumereq), 32'(m_resumereq));
    check({tag, ".ndmreset"}, 32'(ndmreset), 32'(m_ndmreset));
    check({tag, ".ar_valid"}, 32'(ar_valid), 32'(m_busy));
    if (m_busy) begin
      check({tag, ".ar_write"}, 32'(ar_write), 32'(m_ar_write));
      check({tag, ".ar_regno"}, 32'(ar_regno), 32'(m_regno));
      check({tag, ".ar_wdata"}, ar_wdata, m_wdata);
    end
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] c;
    c = $urandom;
    c[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0;
    c[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
    c[17]    = ($urandom_range(0, 4) != 0);
    return c;
  endfunction

  task automatic random_dmi();
    logic [1:0]  op;
    logic [6:0]  a;
    logic [31:0] wd, rd;
    logic [1:0]  ro;
    int unsigned k;
    k  = $urandom_range(0, 19);
    op = (k < 8) ? 2'd1 : (k < 17) ? 2'd2 : (k < 19) ? 2'd0 : 2'd3;
    case ($urandom_range(0, 6))
      0: a = 7'h04;
      1: a = 7'h10;
      2: a = 7'h11;
      3: a = 7'h12;
      4: a = 7'h16;
      5: a = 7'h17;
      default: a = 7'($urandom);
    endcase
    wd = $urandom;
    if (a == 7'h17) wd = rand_cmd();
    if (a == 7'h10 && $urandom_range(0, 9) != 0) wd[0] = 1'b1;
    dmi(op, a, wd, $urandom_range(0, 2), m_busy && ($urandom_range(0, 3) == 0),
        ($urandom_range(0, 3) == 0), $urandom, rd, ro);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  ro;
    trst = 1; req_valid = 0; req_addr = 0; req_data = 0; req_op = 0; rsp_ready = 0;
    hart_halted = 0; hart_resumeack = 0; ar_done = 0; ar_err = 0; ar_rdata = 0;
    model_reset();
    repeat (3) @(posedge tclk);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data", rsp_data, 32'd0);
    check("rst.ar_regno", 32'(ar_regno), 32'd0);
    check("rst.ar_wdata", ar_wdata, 32'd0);
    check_outputs("rst");
    @(negedge tclk); trst = 0;

    rdr(7'h11, rd); check("dmstatus_reset", rd, 32'h0000_0C82);
    rdr(7'h12, rd); check("hartinfo", rd, HartInfo);

    wr(7'h10, 32'h8000_0001);
    check("haltreq_set", 32'(haltreq), 32'd1);
    @(negedge tclk); hart_halted = 1;
    rdr(7'h11, rd); check("dmstatus_halted", rd & 32'hF00, 32'h300);

    wr(7'h10, 32'h4000_0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge tclk); #1;
      check("resumereq_hold", 32'(resumereq), 32'd1);
    end
    pulse_ack();
    check("resumereq_drop", 32'(resumereq), 32'd0);
    rdr(7'h11, rd); check("dmstatus_resumeack", rd & 32'h3_0000, 32'h3_0000);

    wr(7'h04, 32'hDEAD_BEEF);
    wr(7'h17, 32'h0023_1001);
    check("ar_valid", 32'(ar_valid), 32'd1);
    check("ar_write", 32'(ar_write), 32'd1);
    check("ar_regno", 32'(ar_regno), 32'h1001);
    check("ar_wdata", ar_wdata, 32'hDEAD_BEEF);
    wr(7'h17, 32'h0023_1001);
    rdr(7'h16, rd); check("acs_busy_err", rd, 32'h0000_1101);
    pulse_done(1'b0, 32'h0);
    rdr(7'h16, rd); check("acs_done", rd, 32'h0000_0101);
    wr(7'h16, 32'h700);
    wr(7'h17, 32'h0022_1002);
    check("ar_read", 32'(ar_write), 32'd0);
    pulse_done(1'b0, 32'h1234);
    rdr(7'h04, rd); check("data0_capture", rd, 32'h1234);
    wr(7'h17, 32'h0033_1002);
    rdr(7'h16, rd); check("acs_notsup", rd, 32'h0000_0201);
    wr(7'h16, 32'h700);
    rdr(7'h16, rd); check("acs_cleared", rd, 32'h0000_0001);

    // Completion in the same cycle as an otherwise-violating command write.
    wr(7'h17, 32'h0023_1005);
    dmi(2'd2, 7'h17, 32'h0020_0000, 0, 1'b1, 1'b0, 32'h0, rd, ro);
    rdr(7'h16, rd); check("acs_done_first", rd, 32'h0000_0001);

    dmi(2'd1, 7'h11, 32'd0, 4, 1'b0, 1'b0, 32'd0, rd, ro);
    dmi(2'd3, 7'h04, 32'h5555_5555, 0, 1'b0, 1'b0, 32'd0, rd, ro);
    check("op3_failed", 32'(ro), 32'd2);
    rdr(7'h04, rd); check("op3_no_effect", rd, 32'h1234);
    rdr(7'h55, rd); check("unmapped_read", rd, 32'd0);
    check_outputs("directed");

    for (int it = 0; it < 400; it++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r <= 6) random_dmi();
      else if (r <= 8) pulse_done($urandom_range(0, 3) == 0, $urandom);
      else if (r == 9) pulse_ack();
      else if (r == 10) begin @(negedge tclk); hart_halted = ~hart_halted; end
      else begin
        logic [31:0] cw;
        cw = $urandom & 32'hC000_0003;
        if ($urandom_range(0, 9) != 0) cw[0] = 1'b1;
        wr(7'h10, cw);
      end
      check_outputs("rand");
    end

    // Reset in the middle of an access with a response pending.
    if (m_busy) pulse_done(1'b0, 32'h0);
    wr(7'h10, 32'h8000_0001);
    wr(7'h16, 32'h700);
    @(negedge tclk);
    req_valid = 1; req_op = 2'd2; req_addr = 7'h17; req_data = 32'h0023_1001;
    @(posedge tclk); #1; req_valid = 0; req_op = 0;
    check("pre_rst.ar_valid", 32'(ar_valid), 32'd1);
    check("pre_rst.rsp_valid", 32'(rsp_valid), 32'd1);
    #2 trst = 1;
    #1;
    model_reset();
    check("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst.req_ready", 32'(req_ready), 32'd1);
    check("mid_rst.ar_regno", 32'(ar_regno), 32'd0);
    check_outputs("mid_rst");
    @(negedge tclk); trst = 0;
    rdr(7'h10, rd); check("post_rst.dmcontrol", rd, 32'd0);
    rdr(7'h16, rd); check("post_rst.abstractcs", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
